l2_request_scheduler: RTL and testbench
=======================================

L2_REQUEST_SCHEDULER -- requirements
Module: l2_request_scheduler

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2: requester count; the id port field is $clog2(NUM_PORTS) bits wide.
REQ-002 SHALL have parameter SUB_ID_W, default 2: per-port sub_id width; mem id = {port, sub_id}.
REQ-003 SHALL have port clk  in  1: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  in  NUM_PORTS: per-port request valid.
REQ-006 SHALL have port req_ready  out  NUM_PORTS: per-port request accept.
REQ-007 SHALL have port req  in  NUM_PORTS x l2_request_t (43b): addr[29:0], be, rnw, is_amo, amo_type_or_burst_size[4:0], sub_id.
REQ-008 SHALL have port wr_data  in  NUM_PORTS x 32: per-port write data.
REQ-009 SHALL have port wr_data_valid  in  NUM_PORTS: per-port write data valid.
REQ-010 SHALL have port wr_data_ready  out  NUM_PORTS: per-port write data accept.
REQ-011 SHALL have port mem_req  out  l2_mem_request_t: registered memory request.
REQ-012 SHALL have port mem_req_valid  out  1: memory request valid.
REQ-013 SHALL have port mem_req_ready  in  1: memory request accept.
REQ-014 SHALL have port mem_wr_data  out  32: write data forwarded to memory.
REQ-015 SHALL have port mem_wr_data_valid  out  1: forwarded write data valid.
REQ-016 SHALL have port mem_wr_data_ready  in  1: memory write data accept.
REQ-017 SHALL have port attr_push  out  1: pulse that pushes one l2_data_attributes_t entry.
REQ-018 SHALL have port attr  out  l2_data_attributes_t: {id=port, burst_size, abort_request=0}.
REQ-019 SHALL have port attr_full  in  1: attribute FIFO full.
REQ-020 SHALL have port amo_done  in  1: AMO completion pulse; used only with the REQ-034 macro.

Function
REQ-021 SHALL use FSM states IDLE, ISSUE and WDATA.
REQ-022 In IDLE, SHALL grant one eligible port per cycle.
  - Eligible: req_valid=1, and for reads (rnw=1) attr_full=0.
  - Grant order: round-robin starting at rr_ptr.
  - On grant: req_ready[p]=1 for that cycle only, mem_req/mem_req_valid registered, go to ISSUE.
REQ-023 On a read grant, SHALL assert attr_push for 1 cycle in the same cycle with burst_size=amo_type_or_burst_size when is_amo=0, else 0.
REQ-024 SHALL set rr_ptr to (p+1) mod NUM_PORTS on grant; wrap: port NUM_PORTS-1 -> 0.
REQ-025 In ISSUE, SHALL hold mem_req and mem_req_valid stable until mem_req_ready=1.
  - Then a read returns to IDLE.
  - A write loads beat_cnt=burst_size (0 for AMO) and goes to WDATA.
REQ-026 In WDATA, SHALL connect the granted port combinationally.
  - mem_wr_data=wr_data[p]; mem_wr_data_valid=wr_data_valid[p]; wr_data_ready[p]=mem_wr_data_ready; all other wr_data_ready=0.
  - Each handshake decrements beat_cnt.
  - The handshake at beat_cnt=0 returns to IDLE; total beats = burst_size+1.
REQ-027 SHALL keep req_ready=0 for all ports outside IDLE; minimum one idle cycle between grants.
REQ-028 SHALL produce mem_req.id = {p[$clog2(NUM_PORTS)-1:0], sub_id}, with all other fields passed unchanged.
REQ-029 SHALL grant nothing when all requesting ports are ineligible; rr_ptr is then unchanged.

Reset
REQ-030 On rst_n=0, SHALL immediately force the following, including mid-burst, with no beats resumed after release:
  - FSM=IDLE, rr_ptr=0, beat_cnt=0.
  - mem_req_valid=0, mem_wr_data_valid=0, attr_push=0, req_ready=0, wr_data_ready=0.
  - mem_req=0.
REQ-031 SHALL allow the first grant on the first rising edge after rst_n deasserts.

Configuration
REQ-032 SHALL use the macro L2_SCHEDULER_AMO_LOCK_EN.
REQ-033 Without L2_SCHEDULER_AMO_LOCK_EN, SHALL ignore amo_done and treat AMOs as normal requests.
REQ-034 With L2_SCHEDULER_AMO_LOCK_EN:
  - Accepting an AMO from port p SHALL set lock for p; while locked, only p is eligible.
  - amo_done clears the lock on the next edge.
  - amo_done coincident with a new AMO grant: the lock stays set.
  - Reset clears the lock.

Verification
REQ-035 SHALL cover: both ports read-valid from reset, mem_req_ready=1 -> grants go port0, port1, port0; mem_req.id = 3'b0xx, 3'b1xx; attr_push once per read.
REQ-036 SHALL cover: port1 write burst_size=3, data 0xA0..0xA3 -> exactly 4 mem_wr_data beats in order; req_ready=0 throughout; IDLE after the 4th beat.
REQ-037 SHALL cover: mem_req_ready held 0 for 5 cycles -> mem_req stable and no other port granted.
REQ-038 SHALL cover: attr_full=1 with port0 read and port1 write pending -> port1 write granted, port0 waits until attr_full=0.
REQ-039 SHALL cover: rst_n pulsed low during beat 2 of a 4-beat write -> all outputs 0 asynchronously; after release only a new request is issued.
REQ-040 SHALL cover, with L2_SCHEDULER_AMO_LOCK_EN: port0 AMO then both ports request -> only port0 is granted until amo_done; port1 is granted next.

Source files
------------

// File: rtl/l2_request_scheduler.sv
// Round-robin L2 request scheduler: grants one port, issues its registered memory request
// and streams its write beats. Optional AMO port lock is enabled with L2_SCHEDULER_AMO_LOCK_EN.
module l2_request_scheduler #(
    parameter int NUM_PORTS = 2,
    parameter int SUB_ID_W  = 2
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_PORTS-1:0]                     req_valid,
    output logic [NUM_PORTS-1:0]                     req_ready,
    input  logic [NUM_PORTS*(41+SUB_ID_W)-1:0]       req,
    input  logic [NUM_PORTS*32-1:0]                  wr_data,
    input  logic [NUM_PORTS-1:0]                     wr_data_valid,
    output logic [NUM_PORTS-1:0]                     wr_data_ready,
    output logic [41+$clog2(NUM_PORTS)+SUB_ID_W-1:0] mem_req,
    output logic                                     mem_req_valid,
    input  logic                                     mem_req_ready,
    output logic [31:0]                              mem_wr_data,
    output logic                                     mem_wr_data_valid,
    input  logic                                     mem_wr_data_ready,
    output logic                                     attr_push,
    output logic [$clog2(NUM_PORTS)+5:0]             attr,
    input  logic                                     attr_full,
    input  logic                                     amo_done
);
    localparam int IDX_W   = $clog2(NUM_PORTS);
    localparam int REQ_W   = 41 + SUB_ID_W;
    localparam int BSZ_LSB = SUB_ID_W;
    localparam int AMO_BIT = SUB_ID_W + 5;
    localparam int RNW_BIT = SUB_ID_W + 6;

    typedef enum logic [1:0] {IDLE, ISSUE, WDATA} state_t;

    state_t               state;
    state_t               state_next;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     gnt_port;
    logic [IDX_W-1:0]     scan_idx;
    logic [IDX_W-1:0]     cur_port;
    logic                 cur_write;
    logic [4:0]           cur_beats;
    logic [4:0]           beat_cnt;
    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] port_allowed;
    logic                 gnt_valid;
    logic                 grant;
    logic [REQ_W-1:0]     sel_req;
    logic                 sel_rnw;
    logic                 sel_amo;
    logic [4:0]           sel_bsz;
    logic [31:0]          cur_wdata;
    logic                 cur_wvalid;
    logic                 wr_hs;

`ifdef L2_SCHEDULER_AMO_LOCK_EN
    logic             lock;
    logic [IDX_W-1:0] lock_port;

    // A new AMO grant wins over a coincident amo_done so the lock stays set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock      <= 1'b0;
            lock_port <= '0;
        end else if (grant && sel_amo) begin
            lock      <= 1'b1;
            lock_port <= gnt_port;
        end else if (amo_done) begin
            lock      <= 1'b0;
        end
    end

    always_comb begin
        port_allowed = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            port_allowed[p] = !lock || (lock_port == IDX_W'(p));
    end
`else
    logic unused_amo_done;
    assign unused_amo_done = amo_done;
    assign port_allowed    = '1;
`endif

    // Reads need room in the attribute FIFO before they may be granted.
    always_comb begin
        eligible = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            eligible[p] = req_valid[p] && port_allowed[p] && !(req[p*REQ_W + RNW_BIT] && attr_full);
    end

    always_comb begin
        gnt_valid = 1'b0;
        gnt_port  = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            scan_idx = IDX_W'((int'(rr_ptr) + i) % NUM_PORTS);
            if (!gnt_valid && eligible[scan_idx]) begin
                gnt_valid = 1'b1;
                gnt_port  = scan_idx;
            end
        end
    end

    always_comb begin
        sel_req    = '0;
        cur_wdata  = '0;
        cur_wvalid = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt_port == IDX_W'(p))
                sel_req = req[p*REQ_W +: REQ_W];
            if (cur_port == IDX_W'(p)) begin
                cur_wdata  = wr_data[p*32 +: 32];
                cur_wvalid = wr_data_valid[p];
            end
        end
    end

    assign sel_rnw = sel_req[RNW_BIT];
    assign sel_amo = sel_req[AMO_BIT];
    assign sel_bsz = sel_req[BSZ_LSB +: 5];
    assign wr_hs   = (state == WDATA) && cur_wvalid && mem_wr_data_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Grant-cycle outputs are gated by rst_n so they drop the instant reset asserts.
    always_comb begin
        state_next        = state;
        grant             = 1'b0;
        req_ready         = '0;
        attr_push         = 1'b0;
        attr              = '0;
        wr_data_ready     = '0;
        mem_wr_data       = '0;
        mem_wr_data_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (gnt_valid) begin
                    grant      = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_req_ready)
                    state_next = cur_write ? WDATA : IDLE;
            end
            WDATA: begin
                mem_wr_data       = cur_wdata;
                mem_wr_data_valid = cur_wvalid;
                for (int p = 0; p < NUM_PORTS; p++)
                    wr_data_ready[p] = (cur_port == IDX_W'(p)) && mem_wr_data_ready;
                if (wr_hs && beat_cnt == 5'd0)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (grant && rst_n) begin
            req_ready[gnt_port] = 1'b1;
            if (sel_rnw) begin
                attr_push = 1'b1;
                attr      = {gnt_port, (sel_amo ? 5'd0 : sel_bsz), 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            cur_port      <= '0;
            cur_write     <= 1'b0;
            cur_beats     <= '0;
            beat_cnt      <= '0;
            mem_req       <= '0;
            mem_req_valid <= 1'b0;
        end else begin
            if (grant) begin
                rr_ptr        <= (gnt_port == IDX_W'(NUM_PORTS - 1)) ? '0 : gnt_port + 1'b1;
                cur_port      <= gnt_port;
                cur_write     <= !sel_rnw;
                cur_beats     <= sel_amo ? 5'd0 : sel_bsz;
                mem_req       <= {sel_req[REQ_W-1:SUB_ID_W], gnt_port, sel_req[SUB_ID_W-1:0]};
                mem_req_valid <= 1'b1;
            end
            if (state == ISSUE && mem_req_ready) begin
                mem_req_valid <= 1'b0;
                beat_cnt      <= cur_beats;
            end
            if (wr_hs && beat_cnt != 5'd0)
                beat_cnt <= beat_cnt - 5'd1;
        end
    end
endmodule

// File: tb/tb_l2_request_scheduler.sv
// Randomized self-checking bench for l2_request_scheduler; each round offers requests and
// a transaction-level model predicts the winner, the memory request, attributes and write beats.
module tb_l2_request_scheduler;
    localparam int NUM_PORTS = 2;
    localparam int SUB_ID_W  = 2;
    localparam int REQ_W     = 43;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [85:0] req_bus;
    logic [63:0] wr_data;
    logic [1:0]  wr_data_valid;
    logic [1:0]  wr_data_ready;
    logic [43:0] mem_req;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_wr_data;
    logic        mem_wr_data_valid;
    logic        mem_wr_data_ready;
    logic        attr_push;
    logic [6:0]  attr;
    logic        attr_full;
    logic        amo_done;

    logic [29:0] f_addr [2];
    logic [3:0]  f_be   [2];
    logic        f_rnw  [2];
    logic        f_amo  [2];
    logic [4:0]  f_bsz  [2];
    logic [1:0]  f_sub  [2];

    int checks   = 0;
    int failures = 0;
    int model_rr = 0;
    bit model_lock = 1'b0;
    int model_lock_port = 0;

    always #5 clk = ~clk;

    l2_request_scheduler #(.NUM_PORTS(NUM_PORTS), .SUB_ID_W(SUB_ID_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req(req_bus),
        .wr_data(wr_data), .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
        .mem_req(mem_req), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_wr_data(mem_wr_data), .mem_wr_data_valid(mem_wr_data_valid),
        .mem_wr_data_ready(mem_wr_data_ready),
        .attr_push(attr_push), .attr(attr), .attr_full(attr_full), .amo_done(amo_done)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Round-robin from the model pointer over ports that are valid, not blocked by a full
    // attribute FIFO (reads only) and not locked out by a pending AMO.
    function automatic int pickWinner(input logic [1:0] vm, input logic [1:0] rm, input logic af);
        for (int i = 0; i < NUM_PORTS; i++) begin
            int p = (model_rr + i) % NUM_PORTS;
            if (vm[p] && !(rm[p] && af) && !(model_lock && p != model_lock_port))
                return p;
        end
        return -1;
    endfunction

    task automatic clearInputs();
        req_valid         = '0;
        wr_data_valid     = '0;
        mem_req_ready     = 1'b0;
        mem_wr_data_ready = 1'b0;
        attr_full         = 1'b0;
        amo_done          = 1'b0;
    endtask

    task automatic endRound();
        if ($urandom_range(0, 1) == 1) begin
            amo_done = 1'b1;
            @(negedge clk);
            amo_done = 1'b0;
`ifdef L2_SCHEDULER_AMO_LOCK_EN
            model_lock = 1'b0;
`endif
        end
    endtask

    task automatic applyStimulus(input logic [1:0] valid_mask, input logic [1:0] rnw_mask,
                                 input logic af, input int force_burst, input int reset_beat);
        int          w;
        int          stall;
        int          beats;
        logic [31:0] data;
        logic [43:0] exp_req;
        @(negedge clk);
        for (int p = 0; p < NUM_PORTS; p++) begin
            f_addr[p] = 30'($urandom);
            f_be[p]   = 4'($urandom);
            f_rnw[p]  = rnw_mask[p];
            f_amo[p]  = (force_burst < 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (force_burst >= 0)
                f_bsz[p] = 5'(force_burst);
            else
                f_bsz[p] = f_rnw[p] ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
            f_sub[p]  = 2'($urandom);
            req_bus[p*REQ_W +: REQ_W] = {f_addr[p], f_be[p], f_rnw[p], f_amo[p], f_bsz[p], f_sub[p]};
        end
        req_valid     = valid_mask;
        attr_full     = af;
        mem_req_ready = 1'b0;
        #1;
        w = pickWinner(valid_mask, rnw_mask, af);
        if (w < 0) begin
            checkOutput("no_grant_ready", 64'(req_ready), 64'd0);
            checkOutput("no_grant_push", 64'(attr_push), 64'd0);
            @(negedge clk);
            #1;
            checkOutput("no_grant_mem_valid", 64'(mem_req_valid), 64'd0);
            req_valid = '0;
            endRound();
            return;
        end
        exp_req = {f_addr[w], f_be[w], f_rnw[w], f_amo[w], f_bsz[w], 1'(w), f_sub[w]};
        checkOutput("grant_ready", 64'(req_ready), 64'd1 << w);
        checkOutput("grant_push", 64'(attr_push), 64'(f_rnw[w]));
        if (f_rnw[w])
            checkOutput("grant_attr", 64'(attr), 64'({1'(w), (f_amo[w] ? 5'd0 : f_bsz[w]), 1'b0}));
        model_rr = (w + 1) % NUM_PORTS;
`ifdef L2_SCHEDULER_AMO_LOCK_EN
        if (f_amo[w]) begin
            model_lock      = 1'b1;
            model_lock_port = w;
        end
`endif
        @(negedge clk);
        stall = $urandom_range(0, 5);
        for (int k = 0; k <= stall; k++) begin
            #1;
            checkOutput("issue_valid", 64'(mem_req_valid), 64'd1);
            checkOutput("issue_req", 64'(mem_req), 64'(exp_req));
            checkOutput("issue_no_ready", 64'(req_ready), 64'd0);
            if (k == stall)
                mem_req_ready = 1'b1;
            @(negedge clk);
        end
        mem_req_ready = 1'b0;
        if (f_rnw[w]) begin
            req_valid = '0;
            #1;
            checkOutput("read_done_valid", 64'(mem_req_valid), 64'd0);
            checkOutput("read_done_wvalid", 64'(mem_wr_data_valid), 64'd0);
            endRound();
            return;
        end
        beats = f_amo[w] ? 1 : int'(f_bsz[w]) + 1;
        for (int b = 0; b < beats; b++) begin
            stall = $urandom_range(0, 2);
            for (int s = 0; s < stall; s++) begin
                wr_data_valid[w]     = 1'b0;
                wr_data_valid[1 - w] = 1'($urandom);
                mem_wr_data_ready    = 1'($urandom);
                #1;
                checkOutput("beat_stall_valid", 64'(mem_wr_data_valid), 64'd0);
                checkOutput("beat_stall_ready", 64'(wr_data_ready), mem_wr_data_ready ? (64'd1 << w) : 64'd0);
                @(negedge clk);
            end
            data = (force_burst >= 0) ? 32'hA0 + 32'(b) : $urandom;
            wr_data[w*32 +: 32]       = data;
            wr_data[(1 - w)*32 +: 32] = $urandom;
            wr_data_valid[w]          = 1'b1;
            wr_data_valid[1 - w]      = 1'($urandom);
            mem_wr_data_ready         = 1'b1;
            #1;
            checkOutput("beat_data", 64'(mem_wr_data), 64'(data));
            checkOutput("beat_valid", 64'(mem_wr_data_valid), 64'd1);
            checkOutput("beat_wready", 64'(wr_data_ready), 64'd1 << w);
            checkOutput("beat_no_req_ready", 64'(req_ready), 64'd0);
            if (b == reset_beat) begin
                #1;
                rst_n = 1'b0;
                #1;
                checkOutput("rst_mem_valid", 64'(mem_req_valid), 64'd0);
                checkOutput("rst_mem_req", 64'(mem_req), 64'd0);
                checkOutput("rst_wvalid", 64'(mem_wr_data_valid), 64'd0);
                checkOutput("rst_wready", 64'(wr_data_ready), 64'd0);
                checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
                checkOutput("rst_push", 64'(attr_push), 64'd0);
                @(negedge clk);
                clearInputs();
                rst_n           = 1'b1;
                model_rr        = 0;
                model_lock      = 1'b0;
                #1;
                checkOutput("post_rst_wvalid", 64'(mem_wr_data_valid), 64'd0);
                checkOutput("post_rst_mem_valid", 64'(mem_req_valid), 64'd0);
                return;
            end
            @(negedge clk);
        end
        wr_data_valid     = '0;
        mem_wr_data_ready = 1'b0;
        req_valid         = '0;
        #1;
        checkOutput("write_done_wvalid", 64'(mem_wr_data_valid), 64'd0);
        checkOutput("write_done_wready", 64'(wr_data_ready), 64'd0);
        endRound();
    endtask

    initial begin
        logic [1:0] vm;
        logic [1:0] rm;
        logic       af;
        int         rb;
        rst_n   = 1'b0;
        req_bus = '0;
        wr_data = '0;
        clearInputs();
        for (int p = 0; p < NUM_PORTS; p++)
            req_bus[p*REQ_W + SUB_ID_W + 6] = 1'b1;
        req_valid = 2'b11;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
        checkOutput("reset_mem_valid", 64'(mem_req_valid), 64'd0);
        checkOutput("reset_mem_req", 64'(mem_req), 64'd0);
        checkOutput("reset_push", 64'(attr_push), 64'd0);
        checkOutput("reset_wvalid", 64'(mem_wr_data_valid), 64'd0);
        checkOutput("reset_wready", 64'(wr_data_ready), 64'd0);
        @(negedge clk);
        clearInputs();
        rst_n = 1'b1;

        // Directed scenarios first, then randomized rounds.
        repeat (3) applyStimulus(2'b11, 2'b11, 1'b0, -1, -1);
        applyStimulus(2'b10, 2'b00, 1'b0, 3, -1);
        applyStimulus(2'b11, 2'b01, 1'b1, -1, -1);
        applyStimulus(2'b01, 2'b01, 1'b1, -1, -1);
        applyStimulus(2'b01, 2'b01, 1'b0, -1, -1);
        applyStimulus(2'b10, 2'b00, 1'b0, 3, 1);
        applyStimulus(2'b11, 2'b11, 1'b0, -1, -1);

        for (int r = 0; r < 80; r++) begin
            vm = 2'($urandom);
            rm = 2'($urandom);
            af = ($urandom_range(0, 3) == 0);
            rb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2)) : -1;
            applyStimulus(vm, rm, af, -1, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
